// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one 8N1/8N2 UART transmit line
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DIVISOR   = 1250,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 uart_out
);

  localparam int            BW        = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
  localparam logic [2:0]    LAST_INIT = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [BW-1:0]        baud, baud_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic [7:0]           shift, shift_n;
  logic [2:0]           last, last_n;
  logic [2:0]           grant_n;
  logic                 busy_n;
  logic                 uart_n;
  logic [NUM_REQ-1:0]   ack_n;
  logic                 boundary;
  logic                 found;
  int                   idx;

  // Register every piece of state; reset aborts any frame and idles the line high.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      last     <= LAST_INIT;
      grant_id <= '0;
      busy     <= 1'b0;
      uart_out <= 1'b1;
      req_ack  <= '0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      shift    <= shift_n;
      last     <= last_n;
      grant_id <= grant_n;
      busy     <= busy_n;
      uart_out <= uart_n;
      req_ack  <= ack_n;
    end
  end

  // Next-state logic: round-robin grant in IDLE, then baud-paced start/data/stop sequencing.
  always_comb begin
    state_n    = state;
    baud_n     = baud;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    shift_n    = shift;
    last_n     = last;
    grant_n    = grant_id;
    busy_n     = busy;
    uart_n     = uart_out;
    ack_n      = '0;
    found      = 1'b0;
    idx        = 0;
    boundary   = (baud == BAUD_LAST);

    // Baud counter only runs while a frame is on the line; each wrap is a bit boundary.
    if (state != IDLE) begin
      baud_n = boundary ? '0 : baud + 1'b1;
    end

    case (state)
      IDLE: begin
        baud_n = '0;
        uart_n = 1'b1;
        // Search starts just past the previous winner so every requester gets its turn.
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (!found && req_valid[(int'(last) + k) % NUM_REQ]) begin
            found = 1'b1;
            idx   = (int'(last) + k) % NUM_REQ;
          end
        end
        if (found) begin
          ack_n[idx] = 1'b1;
          shift_n    = req_data[8*idx +: 8];
          grant_n    = 3'(idx);
          last_n     = 3'(idx);
          busy_n     = 1'b1;
          uart_n     = 1'b0;
          state_n    = START;
        end
      end
      START: begin
        if (boundary) begin
          uart_n    = shift[0];
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (boundary) begin
          if (bit_cnt == 3'd7) begin
            uart_n     = 1'b1;
            stop_cnt_n = 1'b0;
            state_n    = STOP;
          end else begin
            shift_n   = shift >> 1;
            uart_n    = shift[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (boundary) begin
          if (STOP_BITS == 1 || stop_cnt) begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a frame-level reference model
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  vld_a, vld_b;
  logic [7:0]  dat_a [4];
  logic [7:0]  dat_b [4];
  logic [31:0] data_a, data_b;
  logic [3:0]  ack_a, ack_b;
  logic [2:0]  gid_a, gid_b;
  logic        busy_a, busy_b, tx_a, tx_b;

  assign data_a = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};
  assign data_b = {dat_b[3], dat_b[2], dat_b[1], dat_b[0]};

  uart_tx_arbiter #(.NUM_REQ(N), .DIVISOR(D), .STOP_BITS(1)) dut_a (
    .clock_in(clk), .reset_in(rst), .req_valid(vld_a), .req_data(data_a),
    .req_ack(ack_a), .grant_id(gid_a), .busy(busy_a), .uart_out(tx_a)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .DIVISOR(D), .STOP_BITS(2)) dut_b (
    .clock_in(clk), .reset_in(rst), .req_valid(vld_b), .req_data(data_b),
    .req_ack(ack_b), .grant_id(gid_b), .busy(busy_b), .uart_out(tx_b)
  );

  logic       use_b;
  logic [3:0] mon_ack;
  logic [2:0] mon_gid;
  logic       mon_busy, mon_tx;
  assign mon_ack  = use_b ? ack_b  : ack_a;
  assign mon_gid  = use_b ? gid_b  : gid_a;
  assign mon_busy = use_b ? busy_b : busy_a;
  assign mon_tx   = use_b ? tx_b   : tx_a;

  int total = 0;
  int bad   = 0;
  int last_a = N - 1;
  int last_b = N - 1;

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Line level expected c cycles after the first start-bit cycle.
  function automatic logic exp_bit(input logic [7:0] b, input int c);
    int k;
    k = c / D;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic check_frame(input int id, input logic [7:0] b, input bit reload,
                             input logic [3:0] mid_drop, output int lat);
    int len;
    int errs;
    len  = (use_b ? 11 : 10) * D;
    errs = 0;
    @(negedge clk);
    lat = 1;
    while (mon_ack == 4'b0 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (mon_ack !== 4'(1 << id)) begin
      bad++;
      $display("FAIL ack_grant got=%b exp=%b", mon_ack, 4'(1 << id));
    end
    total++;
    if (mon_gid !== 3'(id)) begin
      bad++;
      $display("FAIL grant_id got=%0d exp=%0d", mon_gid, id);
    end
    if (use_b) begin
      if (reload) dat_b[id] = 8'($urandom); else vld_b[id] = 1'b0;
    end else begin
      if (reload) dat_a[id] = 8'($urandom); else vld_a[id] = 1'b0;
    end
    for (int c = 0; c < len; c++) begin
      if (c == 16 && mid_drop != 4'b0) begin
        vld_a     = vld_a & ~mid_drop;
        dat_a[id] = ~dat_a[id];
      end
      if (mon_tx !== exp_bit(b, c) || mon_busy !== 1'b1 || (c > 0 && mon_ack !== 4'b0)) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL frame_wave id=%0d byte=%h bad_cycles got=%0d exp=0", id, b, errs);
    end
    total++;
    if (mon_busy !== 1'b0 || mon_tx !== 1'b1) begin
      bad++;
      $display("FAIL frame_end busy got=%b exp=0 tx got=%b exp=1", mon_busy, mon_tx);
    end
  endtask

  task automatic run_a(input bit reload, input logic [3:0] mid_drop, input bit chk_gap);
    int g;
    int lat;
    g = pick(vld_a, last_a);
    check_frame(g, dat_a[g], reload, mid_drop, lat);
    last_a = g;
    if (chk_gap) begin
      total++;
      if (lat !== 1) begin
        bad++;
        $display("FAIL start_gap got=%0d exp=1", lat);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || ack_a !== 4'b0 || gid_a !== 3'd0) begin
      bad++;
      $display("FAIL reset_a got=%b%b%b%0d exp=1000", tx_a, busy_a, |ack_a, gid_a);
    end
    total++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || ack_b !== 4'b0 || gid_b !== 3'd0) begin
      bad++;
      $display("FAIL reset_b got=%b%b%b%0d exp=1000", tx_b, busy_b, |ack_b, gid_b);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || ack_a !== 4'b0) begin
      bad++;
      $display("FAIL idle_after_reset got=%b%b%b exp=100", tx_a, busy_a, |ack_a);
    end
  endtask

  task automatic test_single();
    vld_a[0] = 1'b1;
    dat_a[0] = 8'h55;
    run_a(1'b0, 4'b0, 1'b1);
  endtask

  task automatic test_fairness();
    for (int i = 0; i < N; i++) dat_a[i] = 8'hA0 + 8'(i);
    vld_a = 4'hF;
    for (int i = 0; i < 5; i++) run_a(1'b1, 4'b0, 1'b1);
    vld_a = 4'h0;
  endtask

  task automatic test_priority();
    vld_a = 4'b0100;
    dat_a[2] = 8'($urandom);
    run_a(1'b0, 4'b0, 1'b1);
    vld_a = 4'b1010;
    dat_a[1] = 8'($urandom);
    dat_a[3] = 8'($urandom);
    run_a(1'b0, 4'b0, 1'b1);
    run_a(1'b0, 4'b0, 1'b1);
  endtask

  task automatic test_withdraw();
    vld_a = 4'b1000;
    dat_a[3] = 8'($urandom);
    run_a(1'b0, 4'b0, 1'b1);
    vld_a = 4'b0111;
    for (int i = 0; i < 3; i++) dat_a[i] = 8'($urandom);
    run_a(1'b0, 4'b0010, 1'b1);
    run_a(1'b0, 4'b0, 1'b1);
    total++;
    if (vld_a !== 4'b0) begin
      bad++;
      $display("FAIL withdraw_left got=%b exp=0000", vld_a);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int w;
    d = 8'($urandom);
    vld_a = 4'b0001;
    dat_a[0] = d;
    @(negedge clk);
    w = 0;
    while (ack_a == 4'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (ack_a !== 4'b0001) begin
      bad++;
      $display("FAIL rm_ack got=%b exp=0001", ack_a);
    end
    vld_a[0] = 1'b0;
    repeat (21) @(negedge clk);
    total++;
    if (tx_a !== d[4] || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL rm_bit4 got=%b exp=%b", tx_a, d[4]);
    end
    rst = 1'b1;
    #1;
    total++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || ack_a !== 4'b0) begin
      bad++;
      $display("FAIL rm_async got=%b%b%b exp=100", tx_a, busy_a, |ack_a);
    end
    last_a = N - 1;
    last_b = N - 1;
    @(negedge clk);
    vld_a = 4'b0101;
    dat_a[0] = 8'($urandom);
    dat_a[2] = 8'($urandom);
    @(negedge clk);
    total++;
    if (ack_a !== 4'b0 || tx_a !== 1'b1) begin
      bad++;
      $display("FAIL rm_held got=%b%b exp=00001", ack_a, tx_a);
    end
    rst = 1'b0;
    run_a(1'b0, 4'b0, 1'b0);
    run_a(1'b0, 4'b0, 1'b1);
  endtask

  task automatic test_stop2();
    int g;
    int lat;
    use_b = 1'b1;
    vld_b = 4'b0001;
    dat_b[0] = 8'hFF;
    g = pick(vld_b, last_b);
    check_frame(g, dat_b[g], 1'b0, 4'b0, lat);
    last_b = g;
    vld_b = 4'b1000;
    dat_b[3] = 8'($urandom);
    g = pick(vld_b, last_b);
    check_frame(g, dat_b[g], 1'b0, 4'b0, lat);
    last_b = g;
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL stop2_gap got=%0d exp=1", lat);
    end
    use_b = 1'b0;
  endtask

  task automatic test_random();
    int w;
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld_a[i] && $urandom_range(0, 2) == 0) begin
          vld_a[i] = 1'b1;
          dat_a[i] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        w = $urandom_range(0, N - 1);
        vld_a[w] = 1'b0;
      end
      if (vld_a == 4'b0) begin
        w = $urandom_range(0, N - 1);
        vld_a[w] = 1'b1;
        dat_a[w] = 8'($urandom);
      end
      run_a(1'($urandom_range(0, 1)), 4'b0, 1'b1);
    end
  endtask

  task automatic test_idle_hold();
    int errs;
    errs = 0;
    vld_a = 4'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy_a !== 1'b0 || tx_a !== 1'b1 || ack_a !== 4'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL idle_hold bad_cycles got=%0d exp=0", errs);
    end
  endtask

  initial begin
    use_b = 1'b0;
    vld_a = 4'b0;
    vld_b = 4'b0;
    for (int i = 0; i < N; i++) begin
      dat_a[i] = 8'h00;
      dat_b[i] = 8'h00;
    end
    test_reset();
    test_single();
    test_fairness();
    test_priority();
    test_withdraw();
    test_reset_mid();
    test_stop2();
    test_random();
    test_idle_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmit line between NUM_REQ byte requesters, using round-robin arbitration.
- Contains the baud divider, the frame shifter and the frame-sequencing state machine.
- Replaces ad-hoc per-module UART shifters; status/debug sources (LED state, CPU debug, error reporters) each get a request port.
- Line idles high.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIVISOR, 1250, clock cycles per bit period (>=2); baud counter counts 0..DIVISOR-1.
- STOP_BITS, 1, stop bit periods per frame (1 or 2).

Ports:
- clock_in  input  1  system clock; all state updates on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte-available; held until ack.
- req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i captured.
- grant_id  output  3  index of requester owning the current/last frame.
- busy  output  1  high from capture until the end of the last stop bit.
- uart_out  output  1  serial line, LSB first, 8N1 (or 8N2).

Behaviour:
- Reset (async, immediate):
  - uart_out=1, busy=0, req_ack=0, grant_id=0.
  - state=IDLE, baud counter=0, bit counter=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - Each edge with any req_valid bit set, search from index (last+1) mod NUM_REQ upward with wrap; pick the first set index g.
  - On that edge: shift<=req_data[g]; req_ack[g]<=1 (high exactly the following cycle); grant_id<=g; last<=g; busy<=1; uart_out<=0; baud counter<=0; state<=START.
  - No valid bit set: stay in IDLE, uart_out=1.
- Baud timing: baud counter increments each cycle while not IDLE. When it equals DIVISOR-1 it wraps to 0 and a bit boundary occurs. Every bit period is exactly DIVISOR cycles.
- START boundary: uart_out<=shift[0]; bit counter<=0; state<=DATA.
- DATA boundary:
  - Shift right by 1 and set uart_out to the next bit.
  - After bit 7's period: uart_out<=1; state<=STOP.
- STOP: lasts STOP_BITS*DIVISOR cycles. At its final boundary: state<=IDLE; busy<=0.
- Frame length: (10+STOP_BITS-1)*DIVISOR cycles from the first low cycle to busy falling.
- Back-to-back frames: if any req_valid is set in the first IDLE cycle, the next start bit begins on the following cycle. Minimum inter-frame gap is exactly 1 clock of idle-high beyond the stop bits.
- Handshake:
  - req_valid is sampled only in IDLE.
  - Changes to req_valid/req_data while busy are ignored.
  - A requester that drops valid before being granted is skipped (withdrawn, no ack).
  - A requester may present its next byte in the ack cycle; it is eligible at the next IDLE but yields to other pending requesters.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.
- Simultaneous events: the ack pulse and the first start-bit cycle coincide. Reset asserted in any state aborts the frame; the line returns high immediately. No ack is reissued after reset.
- Width rules:
  - Baud counter width = clog2(DIVISOR).
  - Bit counter is 3 bits plus a stop counter for STOP_BITS=2.
  - grant_id is zero-extended to 3 bits.

Test Plan:
- DIVISOR=4, req 0 sends 0x55: uart_out low 4 cycles; then 1,0,1,0,1,0,1,0 for 4 cycles each; then high 4 cycles. req_ack[0] pulses once in the first low cycle. busy high for 40 cycles.
- All 4 requesters continuously valid with bytes 0xA0..0xA3: grant_id sequence 0,1,2,3,0. Each req_ack is a single-cycle pulse. Each frame starts 1 cycle after the previous busy fall.
- Last grant = 2, then req 1 and req 3 valid together: req 3 is granted first, req 1 next.
- req 1 drops valid mid-frame while req 2 is waiting: req 2 granted after the frame. req 1 never acked. The in-progress frame is unaffected by req_data changes.
- Assert reset_in during DATA bit 4: uart_out=1 and busy=0 asynchronously. After release with req 0 valid, a full fresh frame goes out with priority starting at 0.
- STOP_BITS=2, DIVISOR=4, byte 0xFF: start low 4 cycles, then high 40 cycles. busy falls after 44 cycles.
